// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multi-cycle RV32I controller and its datapath/memory.
// The controller uses the master modport; the datapath/memory side uses slave.
`timescale 1ns/1ps
interface multicycle_control_fsm_if #(
  parameter int RETIRE_W = 32
);
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                funct7_5;
  logic                mem_ready;
  logic                br_taken;
  logic [2:0]          state;
  logic                mem_req;
  logic                mem_we;
  logic                ir_we;
  logic                pc_we;
  logic [1:0]          pc_sel;
  logic                rf_we;
  logic [1:0]          alu_src_a;
  logic [1:0]          alu_src_b;
  logic [3:0]          alu_op;
  logic [1:0]          wb_sel;
  logic                illegal_instr;
  logic                timeout_err;
  logic                instr_done;
  logic [RETIRE_W-1:0] retire_count;

  modport master (
    input  opcode, funct3, funct7_5, mem_ready, br_taken,
    output state, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we,
           alu_src_a, alu_src_b, alu_op, wb_sel,
           illegal_instr, timeout_err, instr_done, retire_count
  );

  modport slave (
    output opcode, funct3, funct7_5, mem_ready, br_taken,
    input  state, mem_req, mem_we, ir_we, pc_we, pc_sel, rf_we,
           alu_src_a, alu_src_b, alu_op, wb_sel,
           illegal_instr, timeout_err, instr_done, retire_count
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with
// variable-latency memory handshake, illegal/timeout traps and a retire counter.
`timescale 1ns/1ps
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT     = 16,
  parameter int TIMEOUT_W       = 5,
  parameter int TRAP_ON_ILLEGAL = 1,
  parameter int RETIRE_W        = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  multicycle_control_fsm_if.master bus
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DECODE    = 3'd1;
  localparam logic [2:0] S_EXECUTE   = 3'd2;
  localparam logic [2:0] S_MEMORY    = 3'd3;
  localparam logic [2:0] S_WRITEBACK = 3'd4;
  localparam logic [2:0] S_TRAP      = 3'd5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  // A zero timeout disables the trap; the compare value is then irrelevant.
  localparam logic                 TIMEOUT_EN = (MEM_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST  = TIMEOUT_W'(MEM_TIMEOUT - 1);

  function automatic logic [3:0] alu_op_f(input logic [2:0] f3, input logic f7_5);
    logic [3:0] op;
    case (f3)
      3'b000:  op = f7_5 ? 4'b0001 : 4'b0000;
      3'b001:  op = 4'b0100;
      3'b010:  op = 4'b0111;
      3'b011:  op = 4'b0011;
      3'b100:  op = 4'b0101;
      3'b101:  op = f7_5 ? 4'b1001 : 4'b0110;
      3'b110:  op = 4'b1000;
      3'b111:  op = 4'b0010;
      default: op = 4'b0000;
    endcase
    return op;
  endfunction

  logic [2:0]          state_r;
  logic [2:0]          next_state_s;
  logic [TIMEOUT_W-1:0] wait_cnt_r;
  logic                trap_illegal_r;
  logic [RETIRE_W-1:0] retire_count_r;
  logic                timeout_hit_s;

  logic is_r_s, is_i_s, is_load_s, is_store_s, is_br_s;
  logic is_jal_s, is_jalr_s, is_lui_s, is_auipc_s, legal_s;

  logic       mem_req_s, mem_we_s, ir_we_s, pc_we_s, rf_we_s;
  logic [1:0] pc_sel_s, alu_src_a_s, alu_src_b_s, wb_sel_s;
  logic [3:0] alu_op_s;
  logic       illegal_instr_s, timeout_err_s, instr_done_s;

  assign timeout_hit_s = TIMEOUT_EN && (wait_cnt_r == WAIT_LAST);

  // Opcode class decode.
  always_comb begin
    is_r_s     = 1'b0;
    is_i_s     = 1'b0;
    is_load_s  = 1'b0;
    is_store_s = 1'b0;
    is_br_s    = 1'b0;
    is_jal_s   = 1'b0;
    is_jalr_s  = 1'b0;
    is_lui_s   = 1'b0;
    is_auipc_s = 1'b0;
    case (bus.opcode)
      OP_R:     is_r_s     = 1'b1;
      OP_I:     is_i_s     = 1'b1;
      OP_LOAD:  is_load_s  = 1'b1;
      OP_STORE: is_store_s = 1'b1;
      OP_BR:    is_br_s    = 1'b1;
      OP_JAL:   is_jal_s   = 1'b1;
      OP_JALR:  is_jalr_s  = 1'b1;
      OP_LUI:   is_lui_s   = 1'b1;
      OP_AUIPC: is_auipc_s = 1'b1;
      default:  is_r_s     = 1'b0;
    endcase
    legal_s = is_r_s | is_i_s | is_load_s | is_store_s | is_br_s |
              is_jal_s | is_jalr_s | is_lui_s | is_auipc_s;
  end

  // Next-state and datapath control; everything is forced low while rst is high.
  always_comb begin
    next_state_s    = state_r;
    mem_req_s       = 1'b0;
    mem_we_s        = 1'b0;
    ir_we_s         = 1'b0;
    pc_we_s         = 1'b0;
    pc_sel_s        = 2'b00;
    rf_we_s         = 1'b0;
    alu_src_a_s     = 2'b00;
    alu_src_b_s     = 2'b00;
    alu_op_s        = ALU_ADD;
    wb_sel_s        = 2'b00;
    illegal_instr_s = 1'b0;
    timeout_err_s   = 1'b0;
    instr_done_s    = 1'b0;
    if (rst) begin
      next_state_s = S_FETCH;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req_s = 1'b1;
          if (bus.mem_ready) begin
            ir_we_s      = 1'b1;
            next_state_s = S_DECODE;
          end else if (timeout_hit_s) begin
            next_state_s = S_TRAP;
          end else begin
            next_state_s = S_FETCH;
          end
        end
        S_DECODE: begin
          if (legal_s) begin
            next_state_s = S_EXECUTE;
          end else if (TRAP_ON_ILLEGAL != 0) begin
            next_state_s = S_TRAP;
          end else begin
            pc_we_s      = 1'b1;
            pc_sel_s     = 2'b00;
            instr_done_s = 1'b1;
            next_state_s = S_FETCH;
          end
        end
        S_EXECUTE: begin
          if (is_r_s) begin
            alu_op_s = alu_op_f(bus.funct3, bus.funct7_5);
          end else if (is_i_s) begin
            alu_src_b_s = 2'b01;
            alu_op_s    = alu_op_f(bus.funct3, (bus.funct3 == 3'b101) & bus.funct7_5);
          end else if (is_br_s | is_jal_s | is_auipc_s) begin
            alu_src_a_s = 2'b01;
            alu_src_b_s = 2'b01;
          end else if (is_lui_s) begin
            alu_src_a_s = 2'b10;
            alu_src_b_s = 2'b01;
          end else begin
            alu_src_b_s = 2'b01;
          end
          // Branches retire here; jumps redirect PC here and only write rd later.
          if (is_br_s) begin
            pc_we_s      = 1'b1;
            pc_sel_s     = bus.br_taken ? 2'b01 : 2'b00;
            instr_done_s = 1'b1;
            next_state_s = S_FETCH;
          end else if (is_jal_s | is_jalr_s) begin
            pc_we_s      = 1'b1;
            pc_sel_s     = 2'b01;
            next_state_s = S_WRITEBACK;
          end else if (is_load_s | is_store_s) begin
            next_state_s = S_MEMORY;
          end else begin
            next_state_s = S_WRITEBACK;
          end
        end
        S_MEMORY: begin
          mem_req_s = 1'b1;
          mem_we_s  = is_store_s;
          if (bus.mem_ready) begin
            if (is_store_s) begin
              pc_we_s      = 1'b1;
              instr_done_s = 1'b1;
              next_state_s = S_FETCH;
            end else begin
              next_state_s = S_WRITEBACK;
            end
          end else if (timeout_hit_s) begin
            next_state_s = S_TRAP;
          end else begin
            next_state_s = S_MEMORY;
          end
        end
        S_WRITEBACK: begin
          rf_we_s      = 1'b1;
          instr_done_s = 1'b1;
          next_state_s = S_FETCH;
          if (is_load_s) begin
            wb_sel_s = 2'b01;
          end else if (is_jal_s | is_jalr_s) begin
            wb_sel_s = 2'b10;
          end else begin
            wb_sel_s = 2'b00;
          end
          pc_we_s = ~(is_jal_s | is_jalr_s);
        end
        S_TRAP: begin
          pc_we_s         = 1'b1;
          pc_sel_s        = 2'b11;
          illegal_instr_s = trap_illegal_r;
          timeout_err_s   = ~trap_illegal_r;
          next_state_s    = S_FETCH;
        end
        default: next_state_s = S_FETCH;
      endcase
    end
  end

  // State, wait counter, trap cause and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= S_FETCH;
      wait_cnt_r     <= '0;
      trap_illegal_r <= 1'b0;
      retire_count_r <= '0;
    end else begin
      state_r <= next_state_s;
      // Any state change clears the counter, which covers entry to FETCH/MEMORY.
      if (next_state_s != state_r) begin
        wait_cnt_r <= '0;
      end else if (mem_req_s && !bus.mem_ready) begin
        wait_cnt_r <= wait_cnt_r + TIMEOUT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
      if (next_state_s == S_TRAP) begin
        trap_illegal_r <= (state_r == S_DECODE);
      end else begin
        trap_illegal_r <= trap_illegal_r;
      end
      if (instr_done_s) begin
        retire_count_r <= retire_count_r + RETIRE_W'(1);
      end else begin
        retire_count_r <= retire_count_r;
      end
    end
  end

  assign bus.state         = state_r;
  assign bus.mem_req       = mem_req_s;
  assign bus.mem_we        = mem_we_s;
  assign bus.ir_we         = ir_we_s;
  assign bus.pc_we         = pc_we_s;
  assign bus.pc_sel        = pc_sel_s;
  assign bus.rf_we         = rf_we_s;
  assign bus.alu_src_a     = alu_src_a_s;
  assign bus.alu_src_b     = alu_src_b_s;
  assign bus.alu_op        = alu_op_s;
  assign bus.wb_sel        = wb_sel_s;
  assign bus.illegal_instr = illegal_instr_s;
  assign bus.timeout_err   = timeout_err_s;
  assign bus.instr_done    = instr_done_s;
  assign bus.retire_count  = retire_count_r;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: per-cycle expected output vectors are queued
// per instruction and compared cycle by cycle; two parameterisations are exercised.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, ir, pcw;
    logic [1:0] pcs;
    logic       rfw;
    logic [1:0] a, b;
    logic [3:0] op;
    logic [1:0] wb;
    logic       ill, to, done;
  } outv_t;

  typedef struct packed {
    logic  rdy;
    logic  rst;
    outv_t e;
  } step_t;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic       f7;
    logic       br;
    logic [1:0] a, b;
    logic [3:0] op;
    logic [1:0] wb;
    int         cls;   // 0 alu->WB, 1 load, 2 store, 3 branch, 4 jump
  } vec_t;

  logic clk;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;
  int   exp_ret_a = 0;
  step_t q[$];
  vec_t  tbl[20];

  multicycle_control_fsm_if #(.RETIRE_W(2))  aif ();
  multicycle_control_fsm_if #(.RETIRE_W(32)) bif ();

  multicycle_control_fsm #(.MEM_TIMEOUT(4), .TIMEOUT_W(3), .TRAP_ON_ILLEGAL(1), .RETIRE_W(2))
    dut_a (.clk(clk), .rst(rst_a), .bus(aif));
  multicycle_control_fsm #(.MEM_TIMEOUT(16), .TIMEOUT_W(5), .TRAP_ON_ILLEGAL(0), .RETIRE_W(32))
    dut_b (.clk(clk), .rst(rst_b), .bus(bif));

  outv_t act_a, act_b;
  assign act_a = {aif.state, aif.mem_req, aif.mem_we, aif.ir_we, aif.pc_we, aif.pc_sel, aif.rf_we,
                  aif.alu_src_a, aif.alu_src_b, aif.alu_op, aif.wb_sel,
                  aif.illegal_instr, aif.timeout_err, aif.instr_done};
  assign act_b = {bif.state, bif.mem_req, bif.mem_we, bif.ir_we, bif.pc_we, bif.pc_sel, bif.rf_we,
                  bif.alu_src_a, bif.alu_src_b, bif.alu_op, bif.wb_sel,
                  bif.illegal_instr, bif.timeout_err, bif.instr_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic outv_t o(input logic [2:0] st);
    outv_t r;
    r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic vec_t mkv(input string n, input logic [6:0] opc, input logic [2:0] f3,
                               input logic f7, input logic br, input logic [1:0] a,
                               input logic [1:0] b, input logic [3:0] op,
                               input logic [1:0] wb, input int cls);
    vec_t v;
    v.name = n; v.opc = opc; v.f3 = f3; v.f7 = f7; v.br = br;
    v.a = a; v.b = b; v.op = op; v.wb = wb; v.cls = cls;
    return v;
  endfunction

  task automatic push(input logic rdy, input logic r, input outv_t e);
    step_t s;
    s.rdy = rdy; s.rst = r; s.e = e;
    q.push_back(s);
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic play(input string tag);
    step_t s;
    int    n;
    n = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      aif.mem_ready = s.rdy;
      rst_a = s.rst;
      @(negedge clk);
      chk($sformatf("%s.c%0d", tag, n), 32'(act_a), 32'(s.e));
      @(posedge clk);
      #1;
      n++;
    end
    rst_a = 1'b0;
  endtask

  task automatic set_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7, input logic br);
    aif.opcode = opc; aif.funct3 = f3; aif.funct7_5 = f7; aif.br_taken = br;
  endtask

  task automatic run_vec(input vec_t v);
    outv_t e;
    set_instr(v.opc, v.f3, v.f7, v.br);
    e = o(3'd0); e.req = 1'b1; e.ir = 1'b1; push(1'b1, 1'b0, e);
    push(1'b1, 1'b0, o(3'd1));
    e = o(3'd2); e.a = v.a; e.b = v.b; e.op = v.op;
    if (v.cls == 3) begin
      e.pcw = 1'b1; e.pcs = v.br ? 2'b01 : 2'b00; e.done = 1'b1;
      push(1'b1, 1'b0, e);
    end else if (v.cls == 4) begin
      e.pcw = 1'b1; e.pcs = 2'b01;
      push(1'b1, 1'b0, e);
      e = o(3'd4); e.rfw = 1'b1; e.done = 1'b1; e.wb = v.wb;
      push(1'b1, 1'b0, e);
    end else if (v.cls == 2) begin
      push(1'b1, 1'b0, e);
      e = o(3'd3); e.req = 1'b1; e.we = 1'b1; e.pcw = 1'b1; e.done = 1'b1;
      push(1'b1, 1'b0, e);
    end else begin
      push(1'b1, 1'b0, e);
      if (v.cls == 1) begin
        e = o(3'd3); e.req = 1'b1;
        push(1'b1, 1'b0, e);
      end
      e = o(3'd4); e.rfw = 1'b1; e.done = 1'b1; e.wb = v.wb; e.pcw = 1'b1;
      push(1'b1, 1'b0, e);
    end
    play(v.name);
    exp_ret_a = (exp_ret_a + 1) & 3;
    chk({v.name, ".retire"}, 32'(aif.retire_count), 32'(exp_ret_a));
  endtask

  initial begin
    outv_t e;
    tbl[0]  = mkv("ADD",   7'b0110011, 3'b000, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0000, 2'b00, 0);
    tbl[1]  = mkv("SUB",   7'b0110011, 3'b000, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0001, 2'b00, 0);
    tbl[2]  = mkv("SRA",   7'b0110011, 3'b101, 1'b1, 1'b0, 2'b00, 2'b00, 4'b1001, 2'b00, 0);
    tbl[3]  = mkv("SLTU",  7'b0110011, 3'b011, 1'b0, 1'b0, 2'b00, 2'b00, 4'b0011, 2'b00, 0);
    tbl[4]  = mkv("AND7",  7'b0110011, 3'b111, 1'b1, 1'b0, 2'b00, 2'b00, 4'b0010, 2'b00, 0);
    tbl[5]  = mkv("ADDI30",7'b0010011, 3'b000, 1'b1, 1'b0, 2'b00, 2'b01, 4'b0000, 2'b00, 0);
    tbl[6]  = mkv("SRAI",  7'b0010011, 3'b101, 1'b1, 1'b0, 2'b00, 2'b01, 4'b1001, 2'b00, 0);
    tbl[7]  = mkv("SRLI",  7'b0010011, 3'b101, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0110, 2'b00, 0);
    tbl[8]  = mkv("SLLI",  7'b0010011, 3'b001, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0100, 2'b00, 0);
    tbl[9]  = mkv("XORI",  7'b0010011, 3'b100, 1'b1, 1'b0, 2'b00, 2'b01, 4'b0101, 2'b00, 0);
    tbl[10] = mkv("ORI",   7'b0010011, 3'b110, 1'b0, 1'b0, 2'b00, 2'b01, 4'b1000, 2'b00, 0);
    tbl[11] = mkv("SLTI",  7'b0010011, 3'b010, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0111, 2'b00, 0);
    tbl[12] = mkv("LW",    7'b0000011, 3'b010, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 2'b01, 1);
    tbl[13] = mkv("SW",    7'b0100011, 3'b010, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 2'b00, 2);
    tbl[14] = mkv("BEQt",  7'b1100011, 3'b000, 1'b0, 1'b1, 2'b01, 2'b01, 4'b0000, 2'b00, 3);
    tbl[15] = mkv("BNEn",  7'b1100011, 3'b001, 1'b0, 1'b0, 2'b01, 2'b01, 4'b0000, 2'b00, 3);
    tbl[16] = mkv("JAL",   7'b1101111, 3'b000, 1'b0, 1'b0, 2'b01, 2'b01, 4'b0000, 2'b10, 4);
    tbl[17] = mkv("JALR",  7'b1100111, 3'b000, 1'b0, 1'b0, 2'b00, 2'b01, 4'b0000, 2'b10, 4);
    tbl[18] = mkv("LUI",   7'b0110111, 3'b000, 1'b0, 1'b0, 2'b10, 2'b01, 4'b0000, 2'b00, 0);
    tbl[19] = mkv("AUIPC", 7'b0010111, 3'b000, 1'b0, 1'b0, 2'b01, 2'b01, 4'b0000, 2'b00, 0);

    rst_a = 1'b1; rst_b = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    aif.mem_ready = 1'b1;
    bif.opcode = 7'h7F; bif.funct3 = 3'b000; bif.funct7_5 = 1'b0;
    bif.br_taken = 1'b0; bif.mem_ready = 1'b1;

    // Reset: all strobes/selects low while rst is high.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset.outputs", 32'(act_a), 32'(o(3'd0)));
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk("reset.retire", 32'(aif.retire_count), 32'd0);

    for (int i = 0; i < 20; i++) run_vec(tbl[i]);

    // LW with three wait cycles in MEMORY: 8 cycles total.
    set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
    e = o(3'd0); e.req = 1'b1; e.ir = 1'b1; push(1'b1, 1'b0, e);
    push(1'b1, 1'b0, o(3'd1));
    e = o(3'd2); e.b = 2'b01; push(1'b1, 1'b0, e);
    e = o(3'd3); e.req = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, e);
    push(1'b1, 1'b0, e);
    e = o(3'd4); e.rfw = 1'b1; e.done = 1'b1; e.wb = 2'b01; e.pcw = 1'b1; push(1'b1, 1'b0, e);
    play("lw_wait");
    exp_ret_a = (exp_ret_a + 1) & 3;
    chk("lw_wait.retire", 32'(aif.retire_count), 32'(exp_ret_a));

    // FETCH timeout after 4 request cycles, then ready on the last allowed cycle wins.
    set_instr(7'b0110011, 3'b000, 1'b0, 1'b0);
    e = o(3'd0); e.req = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, e);
    e = o(3'd5); e.pcw = 1'b1; e.pcs = 2'b11; e.to = 1'b1; push(1'b0, 1'b0, e);
    e = o(3'd0); e.req = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, e);
    e.ir = 1'b1; push(1'b1, 1'b0, e);
    push(1'b1, 1'b0, o(3'd1));
    push(1'b1, 1'b0, o(3'd2));
    e = o(3'd4); e.rfw = 1'b1; e.done = 1'b1; e.pcw = 1'b1; push(1'b1, 1'b0, e);
    play("fetch_to");
    exp_ret_a = (exp_ret_a + 1) & 3;
    chk("fetch_to.retire", 32'(aif.retire_count), 32'(exp_ret_a));

    // STORE times out in MEMORY: no retire.
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    e = o(3'd0); e.req = 1'b1; e.ir = 1'b1; push(1'b1, 1'b0, e);
    push(1'b1, 1'b0, o(3'd1));
    e = o(3'd2); e.b = 2'b01; push(1'b1, 1'b0, e);
    e = o(3'd3); e.req = 1'b1; e.we = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 1'b0, e);
    e = o(3'd5); e.pcw = 1'b1; e.pcs = 2'b11; e.to = 1'b1; push(1'b1, 1'b0, e);
    play("sw_to");
    chk("sw_to.retire", 32'(aif.retire_count), 32'(exp_ret_a));

    // Illegal opcode traps from DECODE: no retire.
    set_instr(7'h7F, 3'b000, 1'b0, 1'b0);
    e = o(3'd0); e.req = 1'b1; e.ir = 1'b1; push(1'b1, 1'b0, e);
    push(1'b1, 1'b0, o(3'd1));
    e = o(3'd5); e.pcw = 1'b1; e.pcs = 2'b11; e.ill = 1'b1; push(1'b1, 1'b0, e);
    play("illegal");
    chk("illegal.retire", 32'(aif.retire_count), 32'(exp_ret_a));

    // Reset during MEMORY of a SW: outputs drop immediately, FETCH next, count cleared.
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    e = o(3'd0); e.req = 1'b1; e.ir = 1'b1; push(1'b1, 1'b0, e);
    push(1'b1, 1'b0, o(3'd1));
    e = o(3'd2); e.b = 2'b01; push(1'b1, 1'b0, e);
    e = o(3'd3); e.req = 1'b1; e.we = 1'b1; push(1'b0, 1'b0, e);
    push(1'b0, 1'b1, o(3'd3));
    play("rst_mid");
    chk("rst_mid.retire", 32'(aif.retire_count), 32'd0);
    chk("rst_mid.state", 32'(aif.state), 32'd0);
    exp_ret_a = 0;
    run_vec(tbl[13]);

    // TRAP_ON_ILLEGAL=0 instance: illegal retires in DECODE, then a 16-cycle fetch timeout.
    rst_b = 1'b0;
    @(negedge clk);
    e = o(3'd0); e.req = 1'b1; e.ir = 1'b1;
    chk("nop_ill.fetch", 32'(act_b), 32'(e));
    @(posedge clk); #1;
    @(negedge clk);
    e = o(3'd1); e.pcw = 1'b1; e.done = 1'b1;
    chk("nop_ill.decode", 32'(act_b), 32'(e));
    @(posedge clk); #1;
    chk("nop_ill.retire", bif.retire_count, 32'd1);
    bif.mem_ready = 1'b0;
    e = o(3'd0); e.req = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("to16.c%0d", i), 32'(act_b), 32'(e));
      @(posedge clk); #1;
    end
    @(negedge clk);
    e = o(3'd5); e.pcw = 1'b1; e.pcs = 2'b11; e.to = 1'b1;
    chk("to16.trap", 32'(act_b), 32'(e));
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
